// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder: the FSM state encoding and the
//   state enum built on top of it.
//   Configuration macro used by the block: SERIAL_ADDER_SUB_EN (subtract mode).
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    // State encodings kept as named constants so the enum and any debug
    // tooling agree on the raw values.
    localparam logic [1:0] ST_IDLE_ENC = 2'b00;
    localparam logic [1:0] ST_RUN_ENC  = 2'b01;
    localparam logic [1:0] ST_DONE_ENC = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_RUN  = ST_RUN_ENC,
        ST_DONE = ST_DONE_ENC
    } state_t;

    // Width of the bit counter: one bit wider than needed to index WIDTH bits,
    // so the count can reach WIDTH without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// -----------------------------------------------------------------------------
// fa_cell
//   Combinational 1-bit full adder.
//   Ports:
//     a, b   : addend bits
//     cin    : carry in
//     s      : sum bit
//     cout   : carry out
// -----------------------------------------------------------------------------
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder: operands are shifted LSB first through a single full
//   adder cell with a registered carry, one bit per clock. A WIDTH-bit
//   operation takes WIDTH cycles in RUN followed by a one-cycle DONE.
//
//   Optional feature: define SERIAL_ADDER_SUB_EN to add the `sub` port. With
//   sub=1 at acceptance, B is inverted and the carry preloads 1 so the same
//   datapath produces a-b; cout=1 then means "no borrow".
//
//   Ports:
//     clk    : clock, rising edge
//     rst    : asynchronous reset, active low
//     start  : request; accepted in IDLE or DONE
//     a, b   : operands (WIDTH bits)
//     sub    : 0=add, 1=subtract (SERIAL_ADDER_SUB_EN only)
//     busy   : high while in RUN
//     done   : one-cycle pulse when a result completes
//     sum    : last completed result
//     cout   : carry-out of last completed result
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_sh_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             fa_s;
    logic             fa_c;
    logic             sub_w;
    logic [WIDTH-1:0] b_load_d;
    logic [WIDTH-1:0] res_d;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_w = sub;
`else
    assign sub_w = 1'b0;
`endif

    // Subtraction is a + ~b + 1: invert B on load, preload carry with sub_w.
    assign b_load_d = sub_w ? ~b : b;

    // Result bits enter at the MSB and walk down; after WIDTH shifts the
    // first (LSB) result bit sits at bit 0.
    assign res_d = {fa_s, res_sh_q[WIDTH-1:1]};

    fa_cell u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_sh_q   <= a;
                        b_sh_q   <= b_load_d;
                        res_sh_q <= '0;
                        carry_q  <= sub_w;
                        cnt_q    <= '0;
                        state_q  <= ST_RUN;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                    end
                    done_q <= 1'b0;
                end
                ST_RUN: begin
                    // start is deliberately ignored here; shift state only.
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    res_sh_q <= res_d;
                    carry_q  <= fa_c;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        // Publish result only on the edge into DONE so sum/cout
                        // hold steady during any following RUN.
                        sum_q   <= res_d;
                        cout_q  <= fa_c;
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_r = 1'b0;
    logic         start_r = 1'b0;
    logic [W-1:0] a_r = '0;
    logic [W-1:0] b_r = '0;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub_r = 1'b0;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [W-1:0] last_sum  = '0;
    logic         last_cout = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst_r),
        .start (start_r),
        .a     (a_r),
        .b     (b_r),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub_r),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[$];

    // Reference: plain unsigned arithmetic on the whole operands.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
        int unsigned xi, yi;
        xi = x;
        yi = y;
        if (s) return {(xi >= yi), W'(xi - yi)};
        return (W+1)'(xi + yi);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one op from an idle/done cycle (called at a negedge), wait for done.
    // Returns at the negedge in the DONE cycle.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input string nm);
        logic [W:0] e;
        int k;
        bit busy_ok, hold_ok;
        e = model(x, y, s);
        a_r = x;
        b_r = y;
`ifdef SERIAL_ADDER_SUB_EN
        sub_r = s;
`endif
        start_r = 1'b1;
        @(negedge clk);
        start_r = 1'b0;
        k = 0;
        busy_ok = 1;
        hold_ok = 1;
        while (!done && k < 40) begin
            if (busy !== 1'b1) busy_ok = 0;
            if (sum !== last_sum || cout !== last_cout) hold_ok = 0;
            @(negedge clk);
            k++;
        end
        check({nm, " latency"}, k, W);
        check({nm, " busy_run"}, busy_ok, 1);
        check({nm, " hold"}, hold_ok, 1);
        check({nm, " busy_done"}, busy, 0);
        check({nm, " sum"}, sum, e[W-1:0]);
        check({nm, " cout"}, cout, e[W]);
        last_sum  = e[W-1:0];
        last_cout = e[W];
    endtask

    initial begin
        int t1, t2, pulses;
        logic [W:0] e;

        vecs.push_back('{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1});
        vecs.push_back('{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{8'h10, 8'h01, 1'b1, 8'h0F, 1'b1});
        vecs.push_back('{8'h01, 8'h02, 1'b1, 8'hFF, 1'b0});
        vecs.push_back('{8'h05, 8'h05, 1'b1, 8'h00, 1'b1});
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst sum", sum, 0);
        check("rst cout", cout, 0);
        rst_r = 1'b1;

        // Table: first op starts on the first edge after reset release
        foreach (vecs[i]) begin
            e = model(vecs[i].a, vecs[i].b, vecs[i].s);
            check("table model_sum", e[W-1:0], vecs[i].exp_sum);
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, $sformatf("vec%0d", i));
            check($sformatf("vec%0d tbl_sum", i), sum, vecs[i].exp_sum);
            check($sformatf("vec%0d tbl_cout", i), cout, vecs[i].exp_cout);
            @(negedge clk);
            check($sformatf("vec%0d done_1cyc", i), done, 0);
        end

        // Start while busy: second start must be ignored
        a_r = 8'h01; b_r = 8'h01; start_r = 1'b1;
        @(negedge clk); start_r = 1'b0;
        @(negedge clk);
        a_r = 8'hAA; b_r = 8'h55; start_r = 1'b1;
        @(negedge clk); start_r = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                pulses++;
                check("busy_start sum", sum, 8'h02);
                check("busy_start cout", cout, 0);
            end
            @(negedge clk);
        end
        check("busy_start pulses", pulses, 1);
        last_sum = 8'h02; last_cout = 1'b0;

        // Reset mid-operation
        a_r = 8'h12; b_r = 8'h34; start_r = 1'b1;
        @(negedge clk); start_r = 1'b0;
        repeat (3) @(negedge clk);
        rst_r = 1'b0; start_r = 1'b1;
        #1;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst sum", sum, 0);
        check("midrst cout", cout, 0);
        repeat (2) @(negedge clk);
        check("midrst start_ignored", busy, 0);
        start_r = 1'b0; rst_r = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy) pulses++;
            @(negedge clk);
        end
        check("midrst no_done", pulses, 0);
        last_sum = '0; last_cout = 1'b0;

        // Back-to-back: start held in the DONE cycle
        do_op(8'h35, 8'h4A, 1'b0, "b2b_first");
        t1 = cyc;
        do_op(8'h80, 8'h80, 1'b0, "b2b_second");
        t2 = cyc;
        check("b2b spacing", t2 - t1, W + 1);
        check("b2b sum", sum, 8'h00);
        check("b2b cout", cout, 1);
        @(negedge clk);

        // Randomized ops with random idle gaps
        for (int i = 0; i < 30; i++) begin
            logic s;
            s = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom_range(0, 1));
`endif
            do_op(W'($urandom), W'($urandom), s, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
